// File: rtl/ram_async_ctrl_if.sv
// rtl/ram_async_ctrl_if.sv - request/response handshake bundle for ram_async_ctrl
interface ram_async_ctrl_if #(
  parameter int ADDRESS_SIZE = 24,
  parameter int DATA_SIZE    = 16
);
  logic                    reqValid;
  logic                    reqReady;
  logic                    reqWrite;
  logic [ADDRESS_SIZE-1:0] reqAddress;
  logic [DATA_SIZE-1:0]    reqData;
  logic [1:0]              reqByteEn;
  logic                    rspValid;
  logic [DATA_SIZE-1:0]    rspData;

  modport master (
    output reqValid, reqWrite, reqAddress, reqData, reqByteEn,
    input  reqReady, rspValid, rspData
  );

  modport slave (
    input  reqValid, reqWrite, reqAddress, reqData, reqByteEn,
    output reqReady, rspValid, rspData
  );
endinterface

// File: rtl/ram_async_ctrl.sv
// rtl/ram_async_ctrl.sv - async-SRAM access sequencer feeding RAM_interface
// Optional RAM_CTRL_WAIT_EN: stretch ACCESS while synchronized memWait is high.
module ram_async_ctrl #(
  parameter int ADDRESS_SIZE = 24,
  parameter int DATA_SIZE    = 16,
  parameter int WAIT_CYCLES  = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  ram_async_ctrl_if.slave         bus,
  output logic [ADDRESS_SIZE-1:0] outAddress,
  output logic [DATA_SIZE-1:0]    outDataOut,
  output logic                    outDataOe,
  input  logic [DATA_SIZE-1:0]    outDataIn,
  output logic                    lowerByte,
  output logic                    upperByte,
  output logic                    outputEnable,
  output logic                    writeEnable,
  input  logic                    memWait
);
  localparam int CW   = $clog2(WAIT_CYCLES + 1);
  localparam int HALF = DATA_SIZE / 2;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

  state_t         state;
  logic [CW-1:0]  count;
  logic           isWrite;
  logic [1:0]     byteEn;
  logic           accessDone;
  logic [DATA_SIZE-1:0] readMasked;

`ifdef RAM_CTRL_WAIT_EN
  logic waitMeta;
  logic waitSync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waitMeta <= 1'b0;
      waitSync <= 1'b0;
    end else begin
      waitMeta <= memWait;
      waitSync <= waitMeta;
    end
  end

  assign accessDone = (count == '0) && !waitSync;
`else
  logic unusedMemWait;
  assign unusedMemWait = memWait;
  assign accessDone    = (count == '0);
`endif

  // Disabled lanes read back as zero so callers never see stale bus bytes.
  always_comb begin
    readMasked = outDataIn;
    if (!byteEn[0]) readMasked[HALF-1:0]         = '0;
    if (!byteEn[1]) readMasked[DATA_SIZE-1:HALF] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bus.reqReady <= 1'b1;
      bus.rspValid <= 1'b0;
      bus.rspData  <= '0;
      outAddress   <= '0;
      outDataOut   <= '0;
      outDataOe    <= 1'b0;
      lowerByte    <= 1'b1;
      upperByte    <= 1'b1;
      outputEnable <= 1'b1;
      writeEnable  <= 1'b1;
      count        <= '0;
      isWrite      <= 1'b0;
      byteEn       <= 2'b00;
    end else begin
      bus.rspValid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.reqValid && bus.reqReady) begin
            state        <= SETUP;
            bus.reqReady <= 1'b0;
            outAddress   <= bus.reqAddress;
            outDataOut   <= bus.reqData;
            outDataOe    <= bus.reqWrite;
            lowerByte    <= ~bus.reqByteEn[0];
            upperByte    <= ~bus.reqByteEn[1];
            isWrite      <= bus.reqWrite;
            byteEn       <= bus.reqByteEn;
          end
        end
        SETUP: begin
          state <= ACCESS;
          count <= CW'(WAIT_CYCLES - 1);
          if (isWrite) writeEnable  <= 1'b0;
          else         outputEnable <= 1'b0;
        end
        ACCESS: begin
          // Sample read data while the strobe is still low on this final cycle.
          if (accessDone) begin
            state        <= HOLD;
            writeEnable  <= 1'b1;
            outputEnable <= 1'b1;
            bus.rspValid <= 1'b1;
            if (!isWrite) bus.rspData <= readMasked;
          end else if (count != '0) begin
            count <= count - 1'b1;
          end
        end
        HOLD: begin
          state        <= IDLE;
          outDataOe    <= 1'b0;
          lowerByte    <= 1'b1;
          upperByte    <= 1'b1;
          bus.reqReady <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_async_ctrl.sv
// tb/tb_ram_async_ctrl.sv - self-checking bench for ram_async_ctrl
module tb_ram_async_ctrl;
  localparam int AW = 24;
  localparam int DW = 16;
  localparam int W  = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] outAddress;
  logic [DW-1:0] outDataOut;
  logic [DW-1:0] outDataIn;
  logic          outDataOe;
  logic          lowerByte;
  logic          upperByte;
  logic          outputEnable;
  logic          writeEnable;
  logic          memWait = 1'b0;

  int nAsserts = 0;
  int nFails   = 0;

  always #5 clk = ~clk;

  ram_async_ctrl_if #(.ADDRESS_SIZE(AW), .DATA_SIZE(DW)) bus ();

  ram_async_ctrl #(.ADDRESS_SIZE(AW), .DATA_SIZE(DW), .WAIT_CYCLES(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus.slave),
    .outAddress   (outAddress),
    .outDataOut   (outDataOut),
    .outDataOe    (outDataOe),
    .outDataIn    (outDataIn),
    .lowerByte    (lowerByte),
    .upperByte    (upperByte),
    .outputEnable (outputEnable),
    .writeEnable  (writeEnable),
    .memWait      (memWait)
  );

  // SRAM model on the pins: word array indexed by the low address byte
  logic [DW-1:0] busMem [0:255] = '{default: '0};
  logic [DW-1:0] refMem [0:255] = '{default: '0};

  assign outDataIn = outputEnable ? 16'hDEAD : busMem[outAddress[7:0]];

  always @(posedge clk) begin
    if (rst_n && !writeEnable) begin
      if (!lowerByte) busMem[outAddress[7:0]][7:0]  <= outDataOut[7:0];
      if (!upperByte) busMem[outAddress[7:0]][15:8] <= outDataOut[15:8];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] laneMask(input logic [15:0] w, input logic [1:0] be);
    return {be[1] ? w[15:8] : 8'h00, be[0] ? w[7:0] : 8'h00};
  endfunction

  task automatic refWrite(input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] be);
    if (be[0]) refMem[a[7:0]][7:0]  = d[7:0];
    if (be[1]) refMem[a[7:0]][15:8] = d[15:8];
  endtask

  task automatic checkIdleOutputs(input string tag);
    check({tag, "_ready"}, 32'(bus.reqReady), 32'd1);
    check({tag, "_rsp"},   32'(bus.rspValid), 32'd0);
    check({tag, "_oe"},    32'(outDataOe),    32'd0);
    check({tag, "_lanes"}, 32'({lowerByte, upperByte}), 32'd3);
    check({tag, "_strb"},  32'({outputEnable, writeEnable}), 32'd3);
  endtask

  task automatic checkResetRegs(input string tag);
    checkIdleOutputs(tag);
    check({tag, "_rdata"}, 32'(bus.rspData), 32'd0);
    check({tag, "_addr"},  32'(outAddress),  32'd0);
    check({tag, "_wdata"}, 32'(outDataOut),  32'd0);
  endtask

  task automatic waitReady(input string tag);
    int budget = 0;
    @(negedge clk);
    while (!bus.reqReady && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    check({tag, "_ready_timeout"}, 32'(bus.reqReady), 32'd1);
  endtask

  task automatic driveReq(input bit wr, input logic [AW-1:0] a, input logic [15:0] d,
                          input logic [1:0] be);
    bus.reqValid   = 1'b1;
    bus.reqWrite   = wr;
    bus.reqAddress = a;
    bus.reqData    = d;
    bus.reqByteEn  = be;
  endtask

  // One complete access; extra = cycles the strobe is stretched, waitDrop = cycle memWait falls.
  task automatic runAccess(input string tag, input bit wr, input logic [AW-1:0] a,
                           input logic [15:0] d, input logic [1:0] be,
                           input int extra, input int waitDrop);
    logic [15:0] expRd;
    int weLow = 0;
    int oeLow = 0;
    expRd = laneMask(refMem[a[7:0]], be);
    if (wr) refWrite(a, d, be);
    waitReady(tag);
    driveReq(wr, a, d, be);
    @(posedge clk);
    #1 bus.reqValid = 1'b0;
    for (int c = 1; c <= W + 4 + extra; c++) begin
      bit busy;
      bit strobe;
      @(negedge clk);
      busy   = (c <= W + 2 + extra);
      strobe = (c >= 2) && (c <= W + 1 + extra);
      if (!writeEnable)  weLow++;
      if (!outputEnable) oeLow++;
      check({tag, "_ready"}, 32'(bus.reqReady), 32'(!busy));
      check({tag, "_rsp"},   32'(bus.rspValid), 32'(c == W + 2 + extra));
      check({tag, "_oe"},    32'(outDataOe),    32'(wr && busy));
      check({tag, "_we"},    32'(writeEnable),  32'(!(wr && strobe)));
      check({tag, "_re"},    32'(outputEnable), 32'(!(!wr && strobe)));
      check({tag, "_excl"},  32'(!outputEnable && (!writeEnable || outDataOe)), 32'd0);
      if (busy) begin
        check({tag, "_addr"},  32'(outAddress), 32'(a));
        check({tag, "_lanes"}, 32'({lowerByte, upperByte}), 32'({!be[0], !be[1]}));
        if (wr) check({tag, "_wdata"}, 32'(outDataOut), 32'(d));
      end else begin
        check({tag, "_lanes_off"}, 32'({lowerByte, upperByte}), 32'd3);
      end
      if (c == W + 2 + extra && !wr)
        check({tag, "_rdata"}, 32'(bus.rspData), 32'(expRd));
      if (c == waitDrop) memWait = 1'b0;
    end
    check({tag, "_strobe_len"}, 32'(wr ? weLow : oeLow), 32'(W + extra));
  endtask

  initial begin
    int readyAt;
    logic [AW-1:0] a;
    bus.reqValid   = 1'b0;
    bus.reqWrite   = 1'b0;
    bus.reqAddress = '0;
    bus.reqData    = '0;
    bus.reqByteEn  = 2'b00;

    repeat (3) @(negedge clk);
    checkResetRegs("in_reset");
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkResetRegs("idle");
    end

    runAccess("wr_beef", 1'b1, 24'h000123, 16'hBEEF, 2'b11, 0, 0);
    runAccess("rd_lo",   1'b0, 24'h000123, 16'h0000, 2'b01, 0, 0);
    check("rd_lo_const", 32'(bus.rspData), 32'h00EF);
    runAccess("rd_none", 1'b0, 24'h000123, 16'h0000, 2'b00, 0, 0);
    runAccess("rd_hi",   1'b0, 24'h000123, 16'h0000, 2'b10, 0, 0);

    // Back-to-back: reqValid stays high across two requests
    waitReady("b2b");
    driveReq(1'b1, 24'h5A0042, 16'h1234, 2'b11);
    refWrite(24'h5A0042, 16'h1234, 2'b11);
    @(posedge clk);
    #1 driveReq(1'b0, 24'h5A0042, 16'h0000, 2'b11);
    readyAt = 0;
    for (int c = 1; c <= 14 && readyAt == 0; c++) begin
      @(negedge clk);
      if (bus.reqReady) readyAt = c;
      else check("b2b_busy_rsp_order", 32'(bus.rspValid), 32'(c == W + 2));
    end
    check("b2b_gap", 32'(readyAt), 32'(W + 3));
    @(posedge clk);
    #1 bus.reqValid = 1'b0;
    for (int c = 1; c <= W + 3; c++) begin
      @(negedge clk);
      check("b2b_second_ready", 32'(bus.reqReady), 32'(c == W + 3));
      check("b2b_second_rsp",   32'(bus.rspValid), 32'(c == W + 2));
      if (c == W + 2) check("b2b_second_rdata", 32'(bus.rspData), 32'h1234);
    end

    // Reset pulse in the middle of a write access
    waitReady("rst");
    driveReq(1'b1, 24'h000077, 16'hC3A5, 2'b11);
    refWrite(24'h000077, 16'hC3A5, 2'b11);
    @(posedge clk);
    #1 bus.reqValid = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_in_access", 32'(writeEnable), 32'd0);
    rst_n = 1'b0;
    #1;
    checkResetRegs("rst_async");
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < W + 4; c++) begin
      @(negedge clk);
      check("rst_no_rsp", 32'(bus.rspValid), 32'd0);
      check("rst_stays_idle", 32'(writeEnable), 32'd1);
    end
    runAccess("after_rst", 1'b0, 24'h000077, 16'h0000, 2'b11, 0, 0);

`ifdef RAM_CTRL_WAIT_EN
    memWait = 1'b1;
    runAccess("wait_rd", 1'b0, 24'h000123, 16'h0000, 2'b11, 7, W + 6);
`endif

    for (int i = 0; i < 24; i++) begin
      a = {16'($urandom), 8'($urandom_range(0, 7))};
      runAccess("rand", 1'($urandom), a, 16'($urandom), 2'($urandom), 0, 0);
    end
    for (int i = 0; i < 8; i++)
      runAccess("sweep", 1'b0, 24'(i), 16'h0000, 2'b11, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
